dram_port_arbiter: RTL and testbench
====================================

// Module: dram_port_arbiter
// PURPOSE
//  Shares the single DLX DRAM port between the core load/store path (CPU) and the
//  debug/memory loader (DBG) that preloads and dumps data memory around a run.
//  Sits between the datapath's dram_enable_cu/dram_r_nw_cu/dram_ready_cu triple and DRAM.
//  Fixed CPU priority, anti-starvation for DBG, and a hang watchdog with a sticky error state.
// PARAMETERS
//  ADDR_W        32  DRAM address width
//  DATA_W        32  DRAM word width
//  STARVE_LIMIT  4   consecutive CPU grants with DBG pending before DBG is forced (>=1)
//  TIMEOUT       16  BUSY cycles without dram_ready before entering ERROR (>=2)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  cpu_req      in   1       CPU request; held with addr/wdata/r_nw stable until cpu_ack
//  cpu_r_nw     in   1       1 = read, 0 = write
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_ack      out  1       one-cycle completion pulse; cpu_rdata valid this cycle
//  cpu_rdata    out  DATA_W  read data to CPU
//  dbg_req/dbg_r_nw/dbg_addr/dbg_wdata  in   1/1/ADDR_W/DATA_W  as CPU, DBG side
//  dbg_ack/dbg_rdata                    out  1/DATA_W           as CPU, DBG side
//  dram_enable  out  1       DRAM access strobe, high for whole access
//  dram_r_nw    out  1       muxed direction
//  dram_addr    out  ADDR_W  muxed address
//  dram_wdata   out  DATA_W  muxed write data
//  dram_rdata   in   DATA_W  DRAM read data, valid when dram_ready=1
//  dram_ready   in   1       DRAM completion, single-cycle
//  err_clr      in   1       leaves ERROR
//  hang_err     out  1       high while in ERROR
//  arb_state    out  2       debug: 0 IDLE, 1 BUSY_CPU, 2 BUSY_DBG, 3 ERROR
// BEHAVIOUR
//  Reset: state IDLE; dram_enable, dram_r_nw, *_ack, hang_err = 0; dram_addr/wdata,
//   *_rdata = 0; starve_cnt = 0, tmo_cnt = 0. Reset mid-access aborts it, no ack issued.
//  IDLE: registered decision on sampled reqs. Only cpu_req -> BUSY_CPU. Only dbg_req ->
//   BUSY_DBG. Both: BUSY_DBG if starve_cnt == STARVE_LIMIT, else BUSY_CPU. None: stay.
//  starve_cnt: +1 on each CPU grant made while dbg_req=1 (saturates at STARVE_LIMIT);
//   cleared on DBG grant or on any IDLE cycle with dbg_req=0.
//  BUSY_x: dram_enable=1, dram_* driven from owner's inputs (registered on grant);
//   tmo_cnt counts BUSY cycles from 1. On dram_ready=1: x_ack=1 and x_rdata=dram_rdata
//   same cycle (combinational), tmo_cnt cleared, next state IDLE. Non-owner ack never set.
//  Latency: req high at edge N -> dram_enable from N+1 -> ack in cycle dram_ready arrives;
//   minimum req-to-ack 2 cycles; one mandatory IDLE cycle between back-to-back accesses.
//  Requester drops req before ack: access still completes, ack still pulses (ignored).
//  Watchdog: tmo_cnt == TIMEOUT with dram_ready=0 -> ERROR; dram_ready in that same cycle wins
//   (normal completion). ERROR: dram_enable=0, no acks, hang_err=1, reqs ignored;
//   err_clr=1 -> IDLE next cycle, counters cleared; ready arriving in ERROR is dropped.
//  arb_state is the registered state code; outputs are glitch-free from registers except
//   *_ack and *_rdata.
// TESTING
//  1 CPU read 0x0000_0040, dram_ready 2 cycles after enable with rdata 0xDEAD_BEEF
//    -> dram_enable high 3 cycles, cpu_ack one pulse with cpu_rdata=0xDEAD_BEEF, dbg_ack=0.
//  2 DBG write 0x100<=0x1234_5678, ready immediate -> dram_r_nw=0, dram_wdata=0x1234_5678,
//    dbg_ack at cycle 2 after req, then arb_state=0.
//  3 cpu_req and dbg_req held continuously, ready immediate, STARVE_LIMIT=4 -> grant order
//    CPU,CPU,CPU,CPU,DBG repeating; no grant gaps other than the IDLE cycles.
//  4 CPU read, dram_ready never asserted, TIMEOUT=16 -> ERROR after 16 BUSY cycles,
//    hang_err=1, dram_enable=0, no ack; err_clr pulse -> IDLE, new CPU read completes.
//  5 dram_ready asserted exactly at the 16th BUSY cycle -> cpu_ack, no ERROR.
//  6 rst asserted mid BUSY_DBG -> all outputs 0 immediately (async), no dbg_ack, IDLE after.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one DRAM port between CPU and debug loader with CPU priority, DBG anti-starvation and a hang watchdog
module dram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_r_nw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_r_nw,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dram_enable,
  output logic              dram_r_nw,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  input  logic [DATA_W-1:0] dram_rdata,
  input  logic              dram_ready,
  input  logic              err_clr,
  output logic              hang_err,
  output logic [1:0]        arb_state
);
  typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DBG, ERROR} state_t;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic            dbg_win;
  // DBG wins when it is alone or when the CPU has starved it long enough
  assign dbg_win   = dbg_req & (~cpu_req | (starve_cnt == S_MAX));
  assign arb_state = state;
  assign cpu_ack   = (state == BUSY_CPU) & dram_ready;
  assign dbg_ack   = (state == BUSY_DBG) & dram_ready;
  assign cpu_rdata = cpu_ack ? dram_rdata : '0;
  assign dbg_rdata = dbg_ack ? dram_rdata : '0;
  // arbitration FSM with registered DRAM-side outputs, starvation and watchdog counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      dram_enable <= 1'b0;
      dram_r_nw   <= 1'b0;
      dram_addr   <= '0;
      dram_wdata  <= '0;
      hang_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          starve_cnt <= (dbg_req && !dbg_win) ? starve_cnt + 1'b1 : '0;
          if (cpu_req || dbg_req) begin
            state       <= dbg_win ? BUSY_DBG : BUSY_CPU;
            dram_enable <= 1'b1;
            dram_r_nw   <= dbg_win ? dbg_r_nw : cpu_r_nw;
            dram_addr   <= dbg_win ? dbg_addr : cpu_addr;
            dram_wdata  <= dbg_win ? dbg_wdata : cpu_wdata;
            tmo_cnt     <= TW'(1);
          end
        end
        BUSY_CPU, BUSY_DBG: begin
          if (dram_ready) begin
            state       <= IDLE;
            dram_enable <= 1'b0;
            tmo_cnt     <= '0;
          end else if (tmo_cnt == T_MAX) begin
            state       <= ERROR;
            dram_enable <= 1'b0;
            hang_err    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          if (err_clr) begin
            state      <= IDLE;
            hang_err   <= 1'b0;
            tmo_cnt    <= '0;
            starve_cnt <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed self-checking bench for dram_port_arbiter
module tb_dram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_r_nw = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_r_nw = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        dram_enable, dram_r_nw;
  logic [31:0] dram_addr, dram_wdata;
  logic [31:0] dram_rdata = '0;
  logic        dram_ready;
  logic        err_clr = 1'b0;
  logic        hang_err;
  logic [1:0]  arb_state;
  logic        auto_rdy = 1'b0, man_rdy = 1'b0;
  int          n_run = 0, n_fail = 0;
  assign dram_ready = auto_rdy ? dram_enable : man_rdy;
  dram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_r_nw(cpu_r_nw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_r_nw(dbg_r_nw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dram_enable(dram_enable), .dram_r_nw(dram_r_nw), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .dram_ready(dram_ready),
    .err_clr(err_clr), .hang_err(hang_err), .arb_state(arb_state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    #1;
    chk("rst_enable", dram_enable, 0);
    chk("rst_state", arb_state, 0);
    chk("rst_hang", hang_err, 0);
    chk("rst_addr", dram_addr, 0);
    chk("rst_acks", {cpu_ack, dbg_ack}, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    // 1: CPU read, ready two cycles after enable
    cpu_req = 1'b1; cpu_r_nw = 1'b1; cpu_addr = 32'h0000_0040;
    tick();
    chk("t1_en1", dram_enable, 1);
    chk("t1_state", arb_state, 1);
    chk("t1_addr", dram_addr, 32'h40);
    chk("t1_rnw", dram_r_nw, 1);
    chk("t1_noack", cpu_ack, 0);
    tick();
    chk("t1_en2", dram_enable, 1);
    tick();
    man_rdy = 1'b1; dram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_en3", dram_enable, 1);
    chk("t1_ack", cpu_ack, 1);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_dbgack", dbg_ack, 0);
    cpu_req = 1'b0;
    tick();
    man_rdy = 1'b0;
    chk("t1_idle", arb_state, 0);
    chk("t1_en_off", dram_enable, 0);
    chk("t1_ack_off", cpu_ack, 0);
    // 2: DBG write, ready immediate
    dbg_req = 1'b1; dbg_r_nw = 1'b0; dbg_addr = 32'h100; dbg_wdata = 32'h1234_5678;
    tick();
    man_rdy = 1'b1;
    #1;
    chk("t2_state", arb_state, 2);
    chk("t2_rnw", dram_r_nw, 0);
    chk("t2_wdata", dram_wdata, 32'h1234_5678);
    chk("t2_addr", dram_addr, 32'h100);
    chk("t2_ack", dbg_ack, 1);
    chk("t2_cpuack", cpu_ack, 0);
    dbg_req = 1'b0;
    tick();
    man_rdy = 1'b0;
    chk("t2_idle", arb_state, 0);
    // 3: both held, ready immediate -> CPU x4 then DBG
    auto_rdy = 1'b1;
    cpu_req = 1'b1; dbg_req = 1'b1; dbg_r_nw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t3_grant%0d", i), arb_state, (i % 5 == 4) ? 2 : 1);
      chk($sformatf("t3_ack%0d", i), {cpu_ack, dbg_ack}, (i % 5 == 4) ? 2'b01 : 2'b10);
      tick();
      chk($sformatf("t3_gap%0d", i), arb_state, 0);
    end
    cpu_req = 1'b0; dbg_req = 1'b0; auto_rdy = 1'b0;
    tick();
    // 4: watchdog timeout into ERROR, then recovery
    cpu_req = 1'b1; cpu_r_nw = 1'b1;
    tick();
    for (int i = 2; i <= 16; i++) tick();
    chk("t4_busy16", arb_state, 1);
    chk("t4_en16", dram_enable, 1);
    tick();
    chk("t4_err", arb_state, 3);
    chk("t4_hang", hang_err, 1);
    chk("t4_en_off", dram_enable, 0);
    man_rdy = 1'b1;
    #1;
    chk("t4_noack", cpu_ack, 0);
    tick();
    man_rdy = 1'b0;
    chk("t4_stuck", arb_state, 3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr", arb_state, 0);
    chk("t4_hang_off", hang_err, 0);
    tick();
    chk("t4_regrant", arb_state, 1);
    man_rdy = 1'b1; dram_rdata = 32'hCAFE_0001;
    #1;
    chk("t4_ack", cpu_ack, 1);
    chk("t4_rdata", cpu_rdata, 32'hCAFE_0001);
    cpu_req = 1'b0;
    tick();
    man_rdy = 1'b0;
    // 5: ready on exactly the 16th BUSY cycle
    cpu_req = 1'b1;
    tick();
    for (int i = 2; i <= 16; i++) tick();
    man_rdy = 1'b1;
    #1;
    chk("t5_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    tick();
    man_rdy = 1'b0;
    chk("t5_idle", arb_state, 0);
    chk("t5_nohang", hang_err, 0);
    // 6: async reset in the middle of a DBG access
    dbg_req = 1'b1; dbg_addr = 32'h200;
    tick();
    chk("t6_busy", arb_state, 2);
    tick();
    #2;
    man_rdy = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_en", dram_enable, 0);
    chk("t6_state", arb_state, 0);
    chk("t6_ack", dbg_ack, 0);
    chk("t6_addr", dram_addr, 0);
    dbg_req = 1'b0; man_rdy = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle", arb_state, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
